nor_bus_ctrl: RTL and testbench
===============================

NOR_BUS_CTRL -- requirements
Module: nor_bus_ctrl

Parameters
REQ-001 SHALL have parameter SETUP_CYC, default 2: number of clk_i cycles with CE# low and address stable before OE#/WE# falls.
REQ-002 SHALL have parameter RD_CYC, default 6: number of clk_i cycles OE# is held low on a read.
REQ-003 SHALL have parameter WP_CYC, default 6: number of clk_i cycles WE# is held low on a write.
REQ-004 SHALL have parameter HOLD_CYC, default 2: number of clk_i cycles after OE#/WE# rises, with CE# still low.
REQ-005 SHALL treat every timing parameter as an 8-bit value in the range 1..255; a value of 0 SHALL behave as 1.

Interface
REQ-006 SHALL have port clk_i, input, 1 bit: the single system clock (240 MHz sysclk).
REQ-007 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port wb_cyc_i, input, 1 bit: Wishbone cycle.
REQ-009 SHALL have port wb_stb_i, input, 1 bit: Wishbone strobe.
REQ-010 SHALL have port wb_we_i, input, 1 bit: 1 means write, 0 means read.
REQ-011 SHALL have port wb_adr_i, input, 26 bits: NOR word address.
REQ-012 SHALL have port wb_dat_i, input, 16 bits: write data.
REQ-013 SHALL have port wb_dat_o, output, 16 bits: read data.
REQ-014 SHALL have port wb_ack_o, output, 1 bit: single-cycle acknowledge.
REQ-015 SHALL have port nor_addr_o, output, 26 bits: NOR address bus.
REQ-016 SHALL have port nor_data_i, input, 16 bits: DQ input from the pad.
REQ-017 SHALL have port nor_data_o, output, 16 bits: DQ output to the pad.
REQ-018 SHALL have port nor_data_oe, output, 1 bit: DQ output enable, active-high.
REQ-019 SHALL have ports nor_ce_o, nor_oe_o and nor_we_o, each an output of 1 bit, each active-low.
REQ-020 SHALL have port nor_ry_i, input, 1 bit: asynchronous RY/BY# from the device.
REQ-021 SHALL have port nor_ry_o, output, 1 bit: synchronized RY/BY#.
REQ-022 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-023 SHALL implement a five-state FSM with states IDLE, SETUP, ACTIVE, HOLD and ACK, using one shared 8-bit down-counter.
REQ-024 SHALL, in IDLE when wb_cyc_i & wb_stb_i is high (cycle 0), register the address, write data and direction, load the counter with SETUP_CYC, and enter SETUP.
- From the cycle after acceptance until ACK, nor_addr_o SHALL hold the latched address.
REQ-025 SHALL, in SETUP: drive nor_ce_o=0 and nor_oe_o=nor_we_o=1; for a write, drive nor_data_oe=1 with the latched data on nor_data_o; on the last cycle, load RD_CYC or WP_CYC and enter ACTIVE.
REQ-026 SHALL, in ACTIVE: drive nor_oe_o=0 for a read, or nor_we_o=0 for a write.
- On the last ACTIVE cycle of a read, nor_data_i SHALL be captured into the wb_dat_o register.
- Then load HOLD_CYC and enter HOLD.
REQ-027 SHALL, in HOLD: drive nor_oe_o=nor_we_o=1, keep nor_ce_o=0, and keep nor_data_oe unchanged; on the last cycle, enter ACK.
REQ-028 SHALL, in ACK: drive nor_ce_o=1 and nor_data_oe=0, pulse wb_ack_o for exactly 1 cycle, then return to IDLE.
- The ack pulse SHALL be suppressed if wb_cyc_i is low in the ACK cycle.
REQ-029 SHALL place the ack at cycle 1+SETUP_CYC+ACTIVE+HOLD_CYC after acceptance; there is no pipelining and no request is accepted outside IDLE.
REQ-030 SHALL NOT abort a transaction if wb_cyc_i or wb_stb_i drops mid-transaction; the NOR cycle SHALL complete with full timing.
REQ-031 SHALL never assert nor_oe_o=0 and nor_we_o=0 together, and SHALL never drive nor_data_oe=1 while nor_oe_o=0.
REQ-032 SHALL hold wb_dat_o stable from capture until the next read capture; writes SHALL NOT alter it.
REQ-033 SHALL produce nor_ry_o through a 2-flop synchronizer, giving 2-cycle latency.
REQ-034 SHALL drive busy_o combinationally from the state.

Reset
REQ-035 SHALL, on assertion of reset_i, asynchronously and immediately (including mid-transaction) set:
- state=IDLE;
- nor_ce_o=nor_oe_o=nor_we_o=1;
- nor_data_oe=0;
- nor_addr_o=0 and nor_data_o=0;
- wb_dat_o=0;
- wb_ack_o=0 and busy_o=0;
- both synchronizer flops to 1, so nor_ry_o=1.
REQ-036 SHALL accept a request in the first clock cycle after reset_i is released, provided wb_cyc_i & wb_stb_i is high.

Verification (SETUP_CYC=2, RD_CYC=WP_CYC=6, HOLD_CYC=2)
REQ-037 SHALL be verified for a read:
- Stimulus: read at 0x1234567, with the model returning 0xBEEF.
- Response: CE# low over cycles 1-10, OE# low over 3-8, wb_ack_o high at cycle 11, wb_dat_o=0xBEEF, nor_data_oe=0 throughout.
REQ-038 SHALL be verified for a write:
- Stimulus: write of 0xA5A5 to 0x0000AAA.
- Response: nor_data_oe=1 with nor_data_o=0xA5A5 over cycles 1-10, WE# low over 3-8, OE# high throughout, ack at cycle 11, wb_dat_o unchanged.
REQ-039 SHALL be verified for back-to-back requests:
- Stimulus: a second request held on wb_stb_i during the first transaction.
- Response: the second request is accepted only in the cycle after the first ack, and there is a minimum of 1 cycle of CE# high between transactions.
REQ-040 SHALL be verified for cycle abort:
- Stimulus: wb_cyc_i drops at cycle 4 of a read.
- Response: the OE#/CE# timing is unchanged and no wb_ack_o is produced.
REQ-041 SHALL be verified for reset mid-transaction:
- Stimulus: reset_i asserted at cycle 5 of a write.
- Response: in the same cycle, WE#=1, CE#=1, nor_data_oe=0 and busy_o=0.
REQ-042 SHALL be verified for RY/BY# and parameter boundaries:
- Stimulus: nor_ry_i pulsed low for 3 cycles.
- Response: nor_ry_o is low for 3 cycles, delayed by 2 cycles.
- Stimulus: all timing parameters set to 0.
- Response: the same behaviour as all parameters set to 1, with ack at cycle 4.

Source files
------------

// File: rtl/nor_bus_ctrl_if.sv
// Bus bundle for the NOR flash controller: Wishbone slave side plus the NOR
// pad side. The controller connects through the slave modport; the master
// modport is the view of whatever drives requests and models the pads.
interface nor_bus_ctrl_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [25:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic [25:0] nor_addr_o;
   logic [15:0] nor_data_i;
   logic [15:0] nor_data_o;
   logic        nor_data_oe;
   logic        nor_ce_o;
   logic        nor_oe_o;
   logic        nor_we_o;
   logic        nor_ry_i;
   logic        nor_ry_o;
   logic        busy_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, nor_data_i, nor_ry_i,
      output wb_dat_o, wb_ack_o, nor_addr_o, nor_data_o, nor_data_oe,
             nor_ce_o, nor_oe_o, nor_we_o, nor_ry_o, busy_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, nor_data_i, nor_ry_i,
      input  wb_dat_o, wb_ack_o, nor_addr_o, nor_data_o, nor_data_oe,
             nor_ce_o, nor_oe_o, nor_we_o, nor_ry_o, busy_o
   );
endinterface

// File: rtl/nor_bus_ctrl.sv
// Wishbone-to-asynchronous-NOR bridge. One request at a time walks through
// SETUP -> ACTIVE -> HOLD -> ACK, each phase timed by a shared 8-bit
// down-counter. Pad strobes are decoded straight from the state so that an
// asynchronous reset releases CE#/OE#/WE# in the same cycle.
module nor_bus_ctrl #(
   parameter logic [7:0] SETUP_CYC = 8'd2,
   parameter logic [7:0] RD_CYC    = 8'd6,
   parameter logic [7:0] WP_CYC    = 8'd6,
   parameter logic [7:0] HOLD_CYC  = 8'd2
) (
   input logic           clk_i,
   input logic           reset_i,
   nor_bus_ctrl_if.slave bus
);

   // A phase length of zero is treated as one cycle.
   function automatic logic [7:0] clamp_cyc(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

   localparam logic [7:0] SETUP_N = clamp_cyc(SETUP_CYC);
   localparam logic [7:0] RD_N    = clamp_cyc(RD_CYC);
   localparam logic [7:0] WP_N    = clamp_cyc(WP_CYC);
   localparam logic [7:0] HOLD_N  = clamp_cyc(HOLD_CYC);

   typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, ACK} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [25:0] addr_q, addr_d;
   logic [15:0] wdat_q, wdat_d;
   logic [15:0] rdat_q, rdat_d;
   logic        we_q, we_d;
   logic        ry_meta_q, ry_sync_q;
   logic        last_cyc;
   logic        in_txn;

   // The counter holds the cycles remaining in the current phase, so 1 marks its last cycle.
   assign last_cyc = (cnt_q <= 8'd1);
   assign in_txn   = (state_q == SETUP) || (state_q == ACTIVE) || (state_q == HOLD);

   // State, phase counter and latched transaction registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 26'd0;
         wdat_q  <= 16'd0;
         rdat_q  <= 16'd0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         we_q    <= we_d;
      end
   end

   // Phase sequencing: accept in IDLE, reload the counter at each phase change, capture read data at the end of ACTIVE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      we_d    = we_q;
      unique case (state_q)
         IDLE: begin
            if (bus.wb_cyc_i && bus.wb_stb_i) begin
               addr_d  = bus.wb_adr_i;
               wdat_d  = bus.wb_dat_i;
               we_d    = bus.wb_we_i;
               cnt_d   = SETUP_N;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (last_cyc) begin
               cnt_d   = we_q ? WP_N : RD_N;
               state_d = ACTIVE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACTIVE: begin
            if (last_cyc) begin
               if (!we_q) begin
                  rdat_d = bus.nor_data_i;
               end
               cnt_d   = HOLD_N;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: begin
            if (last_cyc) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Two-flop synchronizer for the asynchronous RY/BY# pin; idles at ready.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ry_meta_q <= 1'b1;
         ry_sync_q <= 1'b1;
      end else begin
         ry_meta_q <= bus.nor_ry_i;
         ry_sync_q <= ry_meta_q;
      end
   end

   // OE# and WE# are only ever low in ACTIVE and are selected by direction, so they are mutually exclusive.
   assign bus.nor_ce_o    = ~in_txn;
   assign bus.nor_oe_o    = ~((state_q == ACTIVE) && !we_q);
   assign bus.nor_we_o    = ~((state_q == ACTIVE) && we_q);
   assign bus.nor_data_oe = in_txn && we_q;
   assign bus.nor_data_o  = wdat_q;
   assign bus.nor_addr_o  = addr_q;
   assign bus.wb_dat_o    = rdat_q;
   // The ack is dropped when the master has abandoned the cycle.
   assign bus.wb_ack_o    = (state_q == ACK) && bus.wb_cyc_i;
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.nor_ry_o    = ry_sync_q;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Self-checking bench for nor_bus_ctrl: a default-timing instance and an
// all-zero-timing instance share the same stimulus; `sel` picks which one
// is observed. Expected pin behaviour comes from a cycle-offset timeline.
module tb_nor_bus_ctrl;
   localparam int S = 2;
   localparam int A = 6;
   localparam int H = 2;
   localparam int N = S + A + H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic        ry  = 1'b1;
   logic        sel = 1'b0;
   logic [25:0] adr = 26'd0;
   logic [15:0] wdat = 16'd0;
   logic [15:0] ndata = 16'd0;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] exp_rdat = 16'd0;

   logic [4:0]  r_pins [0:15];
   logic        r_ack  [0:15];
   logic [25:0] r_addr [0:15];
   logic [15:0] r_dout [0:15];
   logic [15:0] r_rdat [0:15];

   nor_bus_ctrl_if bd ();
   nor_bus_ctrl_if bz ();

   nor_bus_ctrl u_dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bd.slave)
   );

   nor_bus_ctrl #(
      .SETUP_CYC (8'd0),
      .RD_CYC    (8'd0),
      .WP_CYC    (8'd0),
      .HOLD_CYC  (8'd0)
   ) u_dut0 (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bz.slave)
   );

   assign bd.wb_cyc_i = cyc;   assign bz.wb_cyc_i = cyc;
   assign bd.wb_stb_i = stb;   assign bz.wb_stb_i = stb;
   assign bd.wb_we_i  = we;    assign bz.wb_we_i  = we;
   assign bd.wb_adr_i = adr;   assign bz.wb_adr_i = adr;
   assign bd.wb_dat_i = wdat;  assign bz.wb_dat_i = wdat;
   assign bd.nor_data_i = ndata; assign bz.nor_data_i = ndata;
   assign bd.nor_ry_i = ry;    assign bz.nor_ry_i = ry;

   // Observed outputs, packed pins = {CE#, OE#, WE#, data_oe, busy}.
   logic [4:0]  o_pins;
   logic        o_ack, o_ry;
   logic [25:0] o_addr;
   logic [15:0] o_dout, o_rdat;
   assign o_pins = sel ? {bz.nor_ce_o, bz.nor_oe_o, bz.nor_we_o, bz.nor_data_oe, bz.busy_o}
                       : {bd.nor_ce_o, bd.nor_oe_o, bd.nor_we_o, bd.nor_data_oe, bd.busy_o};
   assign o_ack  = sel ? bz.wb_ack_o   : bd.wb_ack_o;
   assign o_ry   = sel ? bz.nor_ry_o   : bd.nor_ry_o;
   assign o_addr = sel ? bz.nor_addr_o : bd.nor_addr_o;
   assign o_dout = sel ? bz.nor_data_o : bd.nor_data_o;
   assign o_rdat = sel ? bz.wb_dat_o   : bd.wb_dat_o;

   always #5 clk = ~clk;

   // Timeline model: acceptance at cycle 0, CE# low for s+a+h cycles,
   // strobe low over cycles s+1..s+a, ack at s+a+h+1.
   function automatic logic [4:0] exp_pins(input int c, input int s, input int a,
                                          input int h, input bit w);
      bit ce_on, act, busy;
      ce_on = (c >= 1) && (c <= s + a + h);
      act   = (c >= s + 1) && (c <= s + a);
      busy  = (c >= 1) && (c <= s + a + h + 1);
      return {~ce_on, ~(act & ~w), ~(act & w), ce_on & w, busy};
   endfunction

   function automatic logic [15:0] exp_rd(input int c, input int s, input int a, input bit w,
                                         input logic [15:0] prev, input logic [15:0] cap);
      return (!w && c > s + a) ? cap : prev;
   endfunction

   task automatic record(input int c);
      r_pins[c] = o_pins;
      r_ack[c]  = o_ack;
      r_addr[c] = o_addr;
      r_dout[c] = o_dout;
      r_rdat[c] = o_rdat;
   endtask

   // Called at the falling edge of cycle 0: issues one request and records
   // cycles 0..n+1. The pad presents `cap` only on the last strobe cycle.
   task automatic run_txn(input bit w, input logic [25:0] a_adr, input logic [15:0] a_dat,
                          input int s, input int a, input int h, input int drop_c,
                          input bit keep, input logic [15:0] cap);
      int n;
      n = s + a + h;
      record(0);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a_adr; wdat = a_dat;
      ndata = cap ^ 16'($urandom_range(1, 65535));
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         record(c);
         we = 1'($urandom); adr = 26'($urandom); wdat = 16'($urandom);
         ndata = (c == s + a) ? cap : (cap ^ 16'($urandom_range(1, 65535)));
         if (c == drop_c) cyc = 1'b0;
         if (c == n + 1 && !keep) begin
            cyc = 1'b0; stb = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] cap;
      rst = 1'b1; ry = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 26'h3FFFFFF; wdat = 16'hFFFF;
      repeat (3) @(negedge clk);
      n_checks++; if (o_pins !== 5'b11100) begin n_fail++; $display("FAIL reset_pins got=%b exp=%b", o_pins, 5'b11100); end
      n_checks++; if (o_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", o_ack); end
      n_checks++; if (o_addr !== 26'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", o_addr); end
      n_checks++; if (o_dout !== 16'd0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", o_dout); end
      n_checks++; if (o_rdat !== 16'd0) begin n_fail++; $display("FAIL reset_rdat got=%h exp=0", o_rdat); end
      n_checks++; if (o_ry !== 1'b1) begin n_fail++; $display("FAIL reset_ry got=%b exp=1", o_ry); end
      // Release reset with a read already pending: it must be taken at once.
      rst = 1'b0; ry = 1'b1;
      cap = 16'($urandom);
      run_txn(1'b0, 26'h1555555, 16'h0000, S, A, H, 0, 1'b0, cap);
      n_checks++; if (r_pins[1] !== exp_pins(1, S, A, H, 1'b0)) begin n_fail++; $display("FAIL reset_first_accept got=%b exp=%b", r_pins[1], exp_pins(1, S, A, H, 1'b0)); end
      n_checks++; if (r_ack[N+1] !== 1'b1) begin n_fail++; $display("FAIL reset_first_ack got=%b exp=1", r_ack[N+1]); end
      n_checks++; if (r_rdat[N+1] !== cap) begin n_fail++; $display("FAIL reset_first_rdat got=%h exp=%h", r_rdat[N+1], cap); end
      exp_rdat = cap;
   endtask

   task automatic test_read();
      @(negedge clk);
      run_txn(1'b0, 26'h1234567, 16'($urandom), S, A, H, 0, 1'b0, 16'hBEEF);
      for (int c = 1; c <= N + 1; c++) begin
         n_checks++; if (r_pins[c] !== exp_pins(c, S, A, H, 1'b0)) begin n_fail++; $display("FAIL read_pins c=%0d got=%b exp=%b", c, r_pins[c], exp_pins(c, S, A, H, 1'b0)); end
         n_checks++; if (r_ack[c] !== (c == N + 1)) begin n_fail++; $display("FAIL read_ack c=%0d got=%b", c, r_ack[c]); end
         n_checks++; if (r_rdat[c] !== exp_rd(c, S, A, 1'b0, exp_rdat, 16'hBEEF)) begin n_fail++; $display("FAIL read_rdat c=%0d got=%h exp=%h", c, r_rdat[c], exp_rd(c, S, A, 1'b0, exp_rdat, 16'hBEEF)); end
         if (c <= N) begin
            n_checks++; if (r_addr[c] !== 26'h1234567) begin n_fail++; $display("FAIL read_addr c=%0d got=%h exp=1234567", c, r_addr[c]); end
         end
      end
      exp_rdat = 16'hBEEF;
   endtask

   task automatic test_write();
      @(negedge clk);
      run_txn(1'b1, 26'h0000AAA, 16'hA5A5, S, A, H, 0, 1'b0, 16'($urandom));
      for (int c = 1; c <= N + 1; c++) begin
         n_checks++; if (r_pins[c] !== exp_pins(c, S, A, H, 1'b1)) begin n_fail++; $display("FAIL write_pins c=%0d got=%b exp=%b", c, r_pins[c], exp_pins(c, S, A, H, 1'b1)); end
         n_checks++; if (r_ack[c] !== (c == N + 1)) begin n_fail++; $display("FAIL write_ack c=%0d got=%b", c, r_ack[c]); end
         n_checks++; if (r_rdat[c] !== exp_rdat) begin n_fail++; $display("FAIL write_rdat c=%0d got=%h exp=%h", c, r_rdat[c], exp_rdat); end
         if (c <= N) begin
            n_checks++; if (r_dout[c] !== 16'hA5A5) begin n_fail++; $display("FAIL write_dout c=%0d got=%h exp=a5a5", c, r_dout[c]); end
            n_checks++; if (r_addr[c] !== 26'h0000AAA) begin n_fail++; $display("FAIL write_addr c=%0d got=%h exp=0000aaa", c, r_addr[c]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit w1, w2;
      logic [15:0] cap1, cap2;
      w1 = 1'($urandom); w2 = ~w1;
      cap1 = 16'($urandom); cap2 = 16'($urandom);
      @(negedge clk);
      run_txn(w1, 26'($urandom), 16'($urandom), S, A, H, 0, 1'b1, cap1);
      for (int c = 1; c <= N + 1; c++) begin
         n_checks++; if (r_pins[c] !== exp_pins(c, S, A, H, w1)) begin n_fail++; $display("FAIL b2b_first_pins c=%0d got=%b exp=%b", c, r_pins[c], exp_pins(c, S, A, H, w1)); end
         n_checks++; if (r_ack[c] !== (c == N + 1)) begin n_fail++; $display("FAIL b2b_first_ack c=%0d got=%b", c, r_ack[c]); end
      end
      if (!w1) exp_rdat = cap1;
      @(negedge clk);
      run_txn(w2, 26'($urandom), 16'($urandom), S, A, H, 0, 1'b0, cap2);
      n_checks++; if (r_pins[0] !== 5'b11100) begin n_fail++; $display("FAIL b2b_gap got=%b exp=11100", r_pins[0]); end
      for (int c = 1; c <= N + 1; c++) begin
         n_checks++; if (r_pins[c] !== exp_pins(c, S, A, H, w2)) begin n_fail++; $display("FAIL b2b_second_pins c=%0d got=%b exp=%b", c, r_pins[c], exp_pins(c, S, A, H, w2)); end
         n_checks++; if (r_ack[c] !== (c == N + 1)) begin n_fail++; $display("FAIL b2b_second_ack c=%0d got=%b", c, r_ack[c]); end
      end
      if (!w2) exp_rdat = cap2;
   endtask

   task automatic test_abort();
      logic [15:0] cap;
      cap = 16'($urandom);
      @(negedge clk);
      // cyc is released during cycle 3, so it is low for all of cycle 4 onward.
      run_txn(1'b0, 26'($urandom), 16'($urandom), S, A, H, 3, 1'b0, cap);
      for (int c = 1; c <= N + 1; c++) begin
         n_checks++; if (r_pins[c] !== exp_pins(c, S, A, H, 1'b0)) begin n_fail++; $display("FAIL abort_pins c=%0d got=%b exp=%b", c, r_pins[c], exp_pins(c, S, A, H, 1'b0)); end
         n_checks++; if (r_ack[c] !== 1'b0) begin n_fail++; $display("FAIL abort_ack c=%0d got=%b exp=0", c, r_ack[c]); end
      end
      n_checks++; if (r_rdat[N+1] !== cap) begin n_fail++; $display("FAIL abort_rdat got=%h exp=%h", r_rdat[N+1], cap); end
      exp_rdat = cap;
   endtask

   task automatic test_random();
      bit w;
      int drop;
      logic [25:0] a;
      logic [15:0] d, cap;
      for (int t = 0; t < 12; t++) begin
         w = 1'($urandom); a = 26'($urandom); d = 16'($urandom); cap = 16'($urandom);
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0;
         @(negedge clk);
         run_txn(w, a, d, S, A, H, drop, 1'b0, cap);
         for (int c = 1; c <= N + 1; c++) begin
            n_checks++; if (r_pins[c] !== exp_pins(c, S, A, H, w)) begin n_fail++; $display("FAIL rand_pins t=%0d c=%0d got=%b exp=%b", t, c, r_pins[c], exp_pins(c, S, A, H, w)); end
            n_checks++; if (r_ack[c] !== (c == N + 1 && drop == 0)) begin n_fail++; $display("FAIL rand_ack t=%0d c=%0d got=%b drop=%0d", t, c, r_ack[c], drop); end
            n_checks++; if (r_rdat[c] !== exp_rd(c, S, A, w, exp_rdat, cap)) begin n_fail++; $display("FAIL rand_rdat t=%0d c=%0d got=%h exp=%h", t, c, r_rdat[c], exp_rd(c, S, A, w, exp_rdat, cap)); end
            if (c <= N) begin
               n_checks++; if (r_addr[c] !== a) begin n_fail++; $display("FAIL rand_addr t=%0d c=%0d got=%h exp=%h", t, c, r_addr[c], a); end
               if (w) begin
                  n_checks++; if (r_dout[c] !== d) begin n_fail++; $display("FAIL rand_dout t=%0d c=%0d got=%h exp=%h", t, c, r_dout[c], d); end
               end
            end
         end
         if (!w) exp_rdat = cap;
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 26'h2AAAAAA; wdat = 16'h5A5A;
      repeat (5) @(negedge clk);
      stb = 1'b0;
      n_checks++; if (o_pins !== exp_pins(5, S, A, H, 1'b1)) begin n_fail++; $display("FAIL rstmid_before got=%b exp=%b", o_pins, exp_pins(5, S, A, H, 1'b1)); end
      rst = 1'b1;
      #1;
      n_checks++; if (o_pins !== 5'b11100) begin n_fail++; $display("FAIL rstmid_pins got=%b exp=11100", o_pins); end
      n_checks++; if (o_addr !== 26'd0) begin n_fail++; $display("FAIL rstmid_addr got=%h exp=0", o_addr); end
      n_checks++; if (o_dout !== 16'd0) begin n_fail++; $display("FAIL rstmid_dout got=%h exp=0", o_dout); end
      n_checks++; if (o_rdat !== 16'd0) begin n_fail++; $display("FAIL rstmid_rdat got=%h exp=0", o_rdat); end
      n_checks++; if (o_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack got=%b exp=0", o_ack); end
      @(negedge clk);
      rst = 1'b0; cyc = 1'b0;
      exp_rdat = 16'd0;
   endtask

   task automatic test_ry();
      logic hist [0:39];
      logic e, dv;
      int lows;
      lows = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         e = (k >= 2) ? hist[k-2] : 1'b1;
         n_checks++; if (o_ry !== e) begin n_fail++; $display("FAIL ry_sync k=%0d got=%b exp=%b", k, o_ry, e); end
         if (k < 12 && o_ry === 1'b0) lows++;
         if (k < 12) dv = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
         else        dv = 1'($urandom);
         hist[k] = dv;
         ry = dv;
      end
      ry = 1'b1;
      n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL ry_pulse_width got=%0d exp=3", lows); end
   endtask

   task automatic test_param_zero();
      bit w;
      logic [25:0] a;
      logic [15:0] d, cap;
      sel = 1'b1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_rdat = 16'd0;
      for (int t = 0; t < 6; t++) begin
         w = (t % 2 == 1); a = 26'($urandom); d = 16'($urandom); cap = 16'($urandom);
         run_txn(w, a, d, 1, 1, 1, 0, 1'b0, cap);
         for (int c = 1; c <= 4; c++) begin
            n_checks++; if (r_pins[c] !== exp_pins(c, 1, 1, 1, w)) begin n_fail++; $display("FAIL zero_pins t=%0d c=%0d got=%b exp=%b", t, c, r_pins[c], exp_pins(c, 1, 1, 1, w)); end
            n_checks++; if (r_ack[c] !== (c == 4)) begin n_fail++; $display("FAIL zero_ack t=%0d c=%0d got=%b", t, c, r_ack[c]); end
            n_checks++; if (r_rdat[c] !== exp_rd(c, 1, 1, w, exp_rdat, cap)) begin n_fail++; $display("FAIL zero_rdat t=%0d c=%0d got=%h exp=%h", t, c, r_rdat[c], exp_rd(c, 1, 1, w, exp_rdat, cap)); end
            if (c <= 3) begin
               n_checks++; if (r_addr[c] !== a) begin n_fail++; $display("FAIL zero_addr t=%0d c=%0d got=%h exp=%h", t, c, r_addr[c], a); end
               if (w) begin
                  n_checks++; if (r_dout[c] !== d) begin n_fail++; $display("FAIL zero_dout t=%0d c=%0d got=%h exp=%h", t, c, r_dout[c], d); end
               end
            end
         end
         if (!w) exp_rdat = cap;
         @(negedge clk);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_abort();
      test_random();
      test_reset_mid();
      test_ry();
      test_param_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
